day_name_scroller: RTL and testbench

Parametrised day-of-week display engine for the calendar/clock datapath. It holds the current weekday, advances it on a day tick, and drives an N-digit seven-segment bank. Three modes are supported: a static three-letter abbreviation, a scrolling full day name, and a blinking abbreviation for set/edit. It sits between the date counter, which supplies the day tick, and the board's seven-segment pins.

---
 rtl/day_disp_pkg.sv | 77 +++++++
 rtl/seg_glyph.sv | 33 +++
 rtl/day_name_scroller.sv | 155 +++++++++++++++
 tb/tb_day_name_scroller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/day_disp_pkg.sv
// Shared definitions for the weekday display engine: character codes,
// day-name and abbreviation tables, day and mode constants.
package day_disp_pkg;

  typedef enum logic [4:0] {
    C_BLANK  = 5'd0,
    C_M      = 5'd1,
    C_O      = 5'd2,
    C_N_LC   = 5'd3,
    C_T      = 5'd4,
    C_U      = 5'd5,
    C_E      = 5'd6,
    C_W      = 5'd7,
    C_D_LC   = 5'd8,
    C_H_LC   = 5'd9,
    C_U_LC   = 5'd10,
    C_F      = 5'd11,
    C_R_LC   = 5'd12,
    C_I      = 5'd13,
    C_S      = 5'd14,
    C_A      = 5'd15,
    C_T_LC   = 5'd16,
    C_Y      = 5'd17,
    C_N      = 5'd18,
    C_R      = 5'd19,
    C_H      = 5'd20,
    C_D      = 5'd21
  } char_e;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_e;

  localparam logic [2:0] MON = 3'd0;
  localparam logic [2:0] TUE = 3'd1;
  localparam logic [2:0] WED = 3'd2;
  localparam logic [2:0] THU = 3'd3;
  localparam logic [2:0] FRI = 3'd4;
  localparam logic [2:0] SAT = 3'd5;
  localparam logic [2:0] SUN = 3'd6;

  localparam int NAME_MAX = 9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Tables carry an eighth, blank entry so a 3-bit day index is always in range.
  localparam char_e NAME_TAB [8][NAME_MAX] = '{
    '{C_M, C_O, C_N, C_D, C_A, C_Y, C_BLANK, C_BLANK, C_BLANK},
    '{C_T, C_U, C_E, C_S, C_D, C_A, C_Y, C_BLANK, C_BLANK},
    '{C_W, C_E, C_D, C_N, C_E, C_S, C_D, C_A, C_Y},
    '{C_T, C_H, C_U, C_R, C_S, C_D, C_A, C_Y, C_BLANK},
    '{C_F, C_R, C_I, C_D, C_A, C_Y, C_BLANK, C_BLANK, C_BLANK},
    '{C_S, C_A, C_T, C_U, C_R, C_D, C_A, C_Y, C_BLANK},
    '{C_S, C_U, C_N, C_D, C_A, C_Y, C_BLANK, C_BLANK, C_BLANK},
    '{default: C_BLANK}
  };

  localparam logic [3:0] NAME_LEN [8] = '{4'd6, 4'd7, 4'd9, 4'd8, 4'd6, 4'd8, 4'd6, 4'd0};

  localparam char_e ABBR_TAB [8][3] = '{
    '{C_M, C_O,    C_N_LC},
    '{C_T, C_U,    C_E},
    '{C_W, C_E,    C_D_LC},
    '{C_T, C_H_LC, C_U_LC},
    '{C_F, C_R_LC, C_I},
    '{C_S, C_A,    C_T_LC},
    '{C_S, C_U_LC, C_N_LC},
    '{C_BLANK, C_BLANK, C_BLANK}
  };

  // Mode 3 is folded onto static so the restart logic sees 0 and 3 as one mode.
  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_STATIC : mode_e'(m);
  endfunction

endpackage

// File: rtl/seg_glyph.sv
// Character code to active-low seven-segment pattern (abcdefg, MSB = a).
module seg_glyph
  import day_disp_pkg::*;
(
  input  char_e      char_i,
  output logic [6:0] seg_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    seg_o = SEG_BLANK;
    case (char_i)
      C_M:            seg_o = 7'b0001001;
      C_O:            seg_o = 7'b1100010;
      C_N_LC, C_N:    seg_o = 7'b1101010;
      C_T, C_T_LC:    seg_o = 7'b1110000;
      C_U:            seg_o = 7'b1000001;
      C_E:            seg_o = 7'b0110000;
      C_W, C_U_LC:    seg_o = 7'b1100011;
      C_D_LC, C_D:    seg_o = 7'b1000010;
      C_H_LC:         seg_o = 7'b1101000;
      C_F:            seg_o = 7'b0111000;
      C_R_LC, C_R:    seg_o = 7'b1111010;
      C_I:            seg_o = 7'b1111011;
      C_S:            seg_o = 7'b0100100;
      C_A:            seg_o = 7'b0001000;
      C_Y:            seg_o = 7'b1000100;
      C_H:            seg_o = 7'b1001000;
      default:        seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/day_name_scroller.sv
// Weekday register plus static / scrolling / blinking seven-segment renderer.
// The segment bus is registered, so it trails day/pos by one cycle.
module day_name_scroller
  import day_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCROLL_DIV = 25_000_000,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    day_tick,
  input  logic                    set_en,
  input  logic [2:0]              set_day,
  input  logic [1:0]              mode,
  output logic [2:0]              day,
  output logic                    week_wrap,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int L_MAX  = NUM_DIGITS + NAME_MAX;
  localparam int POS_W  = $clog2(L_MAX);
  localparam int IDX_W  = POS_W + 1;
  localparam int SDIV_W = $clog2(SCROLL_DIV);
  localparam int BDIV_W = $clog2(BLINK_DIV);

  logic [2:0]              day_q, day_d;
  logic                    wrap_q, wrap_d;
  mode_e                   mode_q, mode_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [SDIV_W-1:0]       sdiv_q, sdiv_d;
  logic [BDIV_W-1:0]       bdiv_q, bdiv_d;
  logic                    blink_on_q, blink_on_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

  logic                    restart;
  logic [IDX_W-1:0]        scroll_len;
  logic [IDX_W-1:0]        pos_ext;

  // A valid set beats a simultaneous tick; an out-of-range set is simply absent.
  always_comb begin
    day_d  = day_q;
    wrap_d = 1'b0;
    if (set_en && set_day <= SUN) begin
      day_d = set_day;
    end else if (day_tick) begin
      if (day_q == SUN) begin
        day_d  = MON;
        wrap_d = 1'b1;
      end else begin
        day_d = day_q + 3'd1;
      end
    end
  end

  assign mode_d     = decode_mode(mode);
  assign restart    = (day_d != day_q) || (mode_d != mode_q);
  assign scroll_len = IDX_W'(NUM_DIGITS) + IDX_W'(NAME_LEN[day_q]);
  assign pos_ext    = IDX_W'(pos_q);

  // Dividers run only in their own mode and sit at zero otherwise.
  always_comb begin
    pos_d      = pos_q;
    sdiv_d     = '0;
    bdiv_d     = '0;
    blink_on_d = blink_on_q;
    if (restart) begin
      pos_d      = '0;
      blink_on_d = 1'b1;
    end else begin
      if (mode_q == MODE_SCROLL) begin
        if (sdiv_q == SDIV_W'(SCROLL_DIV - 1)) begin
          pos_d = (pos_ext == scroll_len - IDX_W'(1)) ? '0 : pos_q + POS_W'(1);
        end else begin
          sdiv_d = sdiv_q + SDIV_W'(1);
        end
      end
      if (mode_q == MODE_BLINK) begin
        if (bdiv_q == BDIV_W'(BLINK_DIV - 1)) begin
          blink_on_d = ~blink_on_q;
        end else begin
          bdiv_d = bdiv_q + BDIV_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [IDX_W-1:0] raw_idx;
    logic [IDX_W-1:0] win_idx;
    logic [3:0]       name_idx;
    char_e            scroll_ch;
    char_e            static_ch;
    char_e            char_sel;
    logic [6:0]       glyph;

    // Window index into "NUM_DIGITS blanks + name"; at most one wrap is possible.
    always_comb begin
      raw_idx   = pos_ext + IDX_W'(NUM_DIGITS - 1 - k);
      win_idx   = (raw_idx >= scroll_len) ? raw_idx - scroll_len : raw_idx;
      name_idx  = 4'(win_idx - IDX_W'(NUM_DIGITS));
      scroll_ch = (win_idx < IDX_W'(NUM_DIGITS)) ? C_BLANK : NAME_TAB[day_q][name_idx];
    end

    if (k <= 2) begin : g_abbr
      assign static_ch = ABBR_TAB[day_q][2-k];
    end else begin : g_pad
      assign static_ch = C_BLANK;
    end

    always_comb begin
      char_sel = static_ch;
      if (mode_q == MODE_SCROLL) begin
        char_sel = scroll_ch;
      end else if (mode_q == MODE_BLINK && !blink_on_q) begin
        char_sel = C_BLANK;
      end
    end

    seg_glyph u_glyph (
      .char_i (char_sel),
      .seg_o  (glyph)
    );

    assign seg_d[7*k +: 7] = glyph;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q      <= MON;
      wrap_q     <= 1'b0;
      mode_q     <= MODE_STATIC;
      pos_q      <= '0;
      sdiv_q     <= '0;
      bdiv_q     <= '0;
      blink_on_q <= 1'b1;
      seg_q      <= '1;
    end else begin
      day_q      <= day_d;
      wrap_q     <= wrap_d;
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      sdiv_q     <= sdiv_d;
      bdiv_q     <= bdiv_d;
      blink_on_q <= blink_on_d;
      seg_q      <= seg_d;
    end
  end

  assign day       = day_q;
  assign week_wrap = wrap_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_day_name_scroller.sv
// Self-checking bench for day_name_scroller: a vector table, hand-written
// scroll/blink/reset sequences and a randomized run against a string model.
module tb_day_name_scroller;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BD    = 3;
  localparam int SEG_W = 7 * ND;

  localparam logic [SEG_W-1:0] MON_PAT = {7'b1111111, 7'b0001001, 7'b1100010, 7'b1101010};
  localparam logic [SEG_W-1:0] TUE_PAT = {7'b1111111, 7'b1110000, 7'b1000001, 7'b0110000};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             day_tick = 1'b0;
  logic             set_en = 1'b0;
  logic [2:0]       set_day = 3'd0;
  logic [1:0]       mode = 2'd0;
  logic [2:0]       day;
  logic             week_wrap;
  logic [SEG_W-1:0] seg;

  int checks = 0;
  int errors = 0;

  string NAMES [7] = '{"MONDAY", "TUESDAY", "WEDNESDAY", "THURSDAY", "FRIDAY", "SATURDAY", "SUNDAY"};
  string ABBRS [7] = '{"Mon", "TUE", "WEd", "Thu", "Fri", "SAt", "Sun"};

  // Model state: t counts clock edges since the last restart.
  int               m_day;
  int               m_mode;
  int               m_t;
  bit               m_wrap;
  logic [SEG_W-1:0] m_seg;

  typedef struct {
    bit       se;
    bit [2:0] sd;
    bit       tk;
    bit [1:0] md;
    bit [2:0] exp_day;
    bit       exp_wrap;
  } vec_t;

  vec_t vecs [$];

  day_name_scroller #(
    .NUM_DIGITS (ND),
    .SCROLL_DIV (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .day_tick  (day_tick),
    .set_en    (set_en),
    .set_day   (set_day),
    .mode      (mode),
    .day       (day),
    .week_wrap (week_wrap),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      " ":      return 7'b1111111;
      "M":      return 7'b0001001;
      "O", "o": return 7'b1100010;
      "N", "n": return 7'b1101010;
      "T", "t": return 7'b1110000;
      "U":      return 7'b1000001;
      "E":      return 7'b0110000;
      "W", "u": return 7'b1100011;
      "D", "d": return 7'b1000010;
      "h":      return 7'b1101000;
      "H":      return 7'b1001000;
      "F":      return 7'b0111000;
      "R", "r": return 7'b1111010;
      "I", "i": return 7'b1111011;
      "S":      return 7'b0100100;
      "A":      return 7'b0001000;
      "Y":      return 7'b1000100;
      default:  return 7'b0000000;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] render(input int d, input int md, input int t);
    logic [SEG_W-1:0] r;
    string s;
    string ab;
    int len;
    int p;
    r = '1;
    if (md == 1) begin
      s = "";
      for (int i = 0; i < ND; i++) s = {s, " "};
      s = {s, NAMES[d]};
      len = s.len();
      p = (t / SD) % len;
      for (int k = 0; k < ND; k++) r[7*k +: 7] = glyph(s[(p + ND - 1 - k) % len]);
    end else if (md == 0 || ((t / BD) % 2) == 0) begin
      ab = ABBRS[d];
      for (int k = 0; k < 3; k++) r[7*k +: 7] = glyph(ab[2-k]);
    end
    return r;
  endfunction

  function automatic int norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? 0 : int'(m);
  endfunction

  task automatic model_reset();
    m_day  = 0;
    m_mode = 0;
    m_t    = 0;
    m_wrap = 1'b0;
    m_seg  = '1;
  endtask

  task automatic model_step();
    int nd;
    bit nw;
    m_seg = render(m_day, m_mode, m_t);
    nd = m_day;
    nw = 1'b0;
    if (set_en && set_day <= 3'd6) begin
      nd = int'(set_day);
    end else if (day_tick) begin
      nd = (m_day + 1) % 7;
      nw = (m_day == 6);
    end
    if (nd != m_day || norm_mode(mode) != m_mode) m_t = 0;
    else m_t++;
    m_day  = nd;
    m_wrap = nw;
    m_mode = norm_mode(mode);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic apply(input logic se, input logic [2:0] sd, input logic tk, input logic [1:0] md);
    set_en   = se;
    set_day  = sd;
    day_tick = tk;
    mode     = md;
    @(posedge clk);
    model_step();
    @(negedge clk);
    set_en   = 1'b0;
    day_tick = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_day"}, 64'(day), 64'(m_day));
    check({tag, "_wrap"}, 64'(week_wrap), 64'(m_wrap));
    check({tag, "_seg"}, 64'(seg), 64'(m_seg));
  endtask

  initial begin
    vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b1, 2'd0, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b1, 2'd0, 3'd2, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 1'b0, 2'd0, 3'd6, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b1, 2'd0, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 1'b0, 2'd0, 3'd6, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 1'b1, 2'd0, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 2'd0, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b1, 2'd0, 3'd4, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 1'b0, 2'd3, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b1, 2'd3, 3'd6, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b1, 2'd3, 3'd0, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 1'b1, 2'd3, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 3'd0, 1'b0});

    // Reset state, then the first clock after release loads the Monday pattern.
    model_reset();
    #12;
    check("reset_seg", 64'(seg), 64'({SEG_W{1'b1}}));
    check("reset_day", 64'(day), 64'd0);
    check("reset_wrap", 64'(week_wrap), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 3'd0, 1'b0, 2'd0);
    check("first_mon_seg", 64'(seg), 64'(MON_PAT));
    check_all("first");

    foreach (vecs[i]) begin
      apply(vecs[i].se, vecs[i].sd, vecs[i].tk, vecs[i].md);
      check($sformatf("vec%0d_day", i), 64'(day), 64'(vecs[i].exp_day));
      check($sformatf("vec%0d_wrap", i), 64'(week_wrap), 64'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_seg", i), 64'(seg), 64'(m_seg));
    end

    // Scroll Monday: four blank frames, M enters at digit 0, pos wraps after 40 cycles.
    apply(1'b1, 3'd0, 1'b0, 2'd1);
    check_all("scroll_enter");
    for (int c = 1; c <= 45; c++) begin
      apply(1'b0, 3'd0, 1'b0, 2'd1);
      check_all($sformatf("scroll%0d", c));
      if (c <= 4) check($sformatf("scroll_blank%0d", c), 64'(seg), 64'({SEG_W{1'b1}}));
      if (c == 5) check("scroll_first_m", 64'(seg[6:0]), 64'(7'b0001001));
      if (c == 41) check("scroll_wrap_blank", 64'(seg), 64'({SEG_W{1'b1}}));
    end

    // Blink Monday: on 3, off 3; a tick during the off-phase restarts on Tuesday.
    apply(1'b0, 3'd0, 1'b0, 2'd2);
    check_all("blink_enter");
    for (int c = 1; c <= 10; c++) begin
      apply(1'b0, 3'd0, 1'b0, 2'd2);
      check_all($sformatf("blink%0d", c));
      if (c <= 3 || (c >= 7 && c <= 9)) check($sformatf("blink_on%0d", c), 64'(seg), 64'(MON_PAT));
      else check($sformatf("blink_off%0d", c), 64'(seg), 64'({SEG_W{1'b1}}));
    end
    apply(1'b0, 3'd0, 1'b1, 2'd2);
    check_all("blink_tick");
    apply(1'b0, 3'd0, 1'b0, 2'd2);
    check("blink_restart_tue", 64'(seg), 64'(TUE_PAT));
    for (int c = 0; c < 6; c++) begin
      apply(1'b0, 3'd0, 1'b0, 2'd2);
      check_all($sformatf("blink_after%0d", c));
    end

    // Randomized traffic; an invalid set never coincides with a tick.
    for (int i = 0; i < 1500; i++) begin
      logic se;
      logic [2:0] sd;
      logic tk;
      logic [1:0] md;
      md = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : mode;
      se = ($urandom_range(0, 47) == 0);
      sd = 3'($urandom_range(0, 7));
      tk = ($urandom_range(0, 63) == 0);
      if (se && sd == 3'd7) tk = 1'b0;
      apply(se, sd, tk, md);
      check_all($sformatf("rnd%0d", i));
    end

    // Reset asserted mid-scroll blanks the bus at once and scrolling restarts from pos 0.
    apply(1'b1, 3'd2, 1'b0, 2'd1);
    for (int c = 0; c < 15; c++) begin
      apply(1'b0, 3'd0, 1'b0, 2'd1);
      check_all($sformatf("pre_rst%0d", c));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_seg", 64'(seg), 64'({SEG_W{1'b1}}));
    check("midrst_day", 64'(day), 64'd0);
    check("midrst_wrap", 64'(week_wrap), 64'd0);
    @(negedge clk);
    check("midrst_hold_seg", 64'(seg), 64'({SEG_W{1'b1}}));
    rst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= 12; c++) begin
      apply(1'b0, 3'd0, 1'b0, 2'd1);
      check_all($sformatf("post_rst%0d", c));
      if (c == 6) check("post_rst_first_m", 64'(seg[6:0]), 64'(7'b0001001));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
